i2c_xfer_seq: RTL and testbench



---
 rtl/i2c_xfer_seq.sv | 275 +++++++++++++++++++++++++++
 tb/tb_i2c_xfer_seq.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_xfer_seq.sv
// Register-access sequencer that drives the byte-level I2C master (i2c_m) command/data/ds interface.
// Optional build macro I2C_SEQ_RETRY_EN: retry address-NACKed requests up to RETRIES more times.
module i2c_xfer_seq #(
   parameter int unsigned LEN_W   = 4,
   parameter int unsigned RETRIES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_rd,
   input  logic [6:0]       req_dev,
   input  logic [7:0]       req_reg,
   input  logic [LEN_W-1:0] req_len,
   input  logic [7:0]       wr_data,
   input  logic             wr_valid,
   output logic             wr_ready,
   output logic [7:0]       rd_data,
   output logic             rd_valid,
   output logic             done,
   output logic [1:0]       err,
   output logic [4:0]       m_cmd,
   output logic [7:0]       m_dat,
   output logic             m_ds,
   input  logic [3:0]       m_status,
   input  logic [7:0]       m_rdat
);

`ifdef I2C_SEQ_RETRY_EN
   localparam bit RETRY_EN = 1'b1;
`else
   localparam bit RETRY_EN = 1'b0;
`endif

   localparam logic [4:0] CMD_CLRS = 5'h00;
   localparam logic [4:0] CMD_STRT = 5'h01;
   localparam logic [4:0] CMD_STOP = 5'h02;
   localparam logic [4:0] CMD_READ = 5'h04;
   localparam logic [4:0] CMD_WRTE = 5'h08;
   localparam logic [4:0] CMD_NACK = 5'h10;

   localparam logic [1:0] ERR_OK    = 2'd0;
   localparam logic [1:0] ERR_ANACK = 2'd1;
   localparam logic [1:0] ERR_DNACK = 2'd2;
   localparam logic [1:0] ERR_MSTR  = 2'd3;

   typedef enum logic [3:0] {
      S_IDLE, S_ISSUE, S_WAIT1, S_WAITB, S_CHECK, S_WDAT, S_CLR, S_CLRW, S_DONE
   } state_t;

   // Which byte of the transaction is currently in flight on the master.
   typedef enum logic [2:0] {
      P_ADDR, P_REG, P_RADDR, P_WDATA, P_RDATA, P_STOP
   } phase_t;

   state_t           state;
   phase_t           phase;
   logic [LEN_W-1:0] cnt;
   logic             rd_q;
   logic [6:0]       dev_q;
   logic [7:0]       reg_q;
   logic [1:0]       retry_cnt;
   logic [1:0]       pend_err;
   logic             retry_ok;

   logic is_last;
   logic is_next_last;
   logic m_fail;
   logic m_ack;

   assign is_last      = (cnt == LEN_W'(1));
   assign is_next_last = (cnt == LEN_W'(2));
   assign m_fail       = m_status[1] | m_status[2];
   assign m_ack        = m_status[3];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         phase     <= P_ADDR;
         cnt       <= '0;
         rd_q      <= 1'b0;
         dev_q     <= '0;
         reg_q     <= '0;
         retry_cnt <= '0;
         pend_err  <= ERR_OK;
         retry_ok  <= 1'b0;
         req_ready <= 1'b1;
         wr_ready  <= 1'b0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         done      <= 1'b0;
         err       <= ERR_OK;
         m_cmd     <= CMD_CLRS;
         m_dat     <= '0;
         m_ds      <= 1'b0;
      end else begin
         m_ds     <= 1'b0;
         wr_ready <= 1'b0;
         rd_valid <= 1'b0;
         done     <= 1'b0;

         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  rd_q      <= req_rd;
                  dev_q     <= req_dev;
                  reg_q     <= req_reg;
                  cnt       <= req_len;
                  retry_cnt <= '0;
                  retry_ok  <= 1'b0;
                  req_ready <= 1'b0;
                  if (req_len == '0) begin
                     err   <= ERR_MSTR;
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     m_cmd <= CMD_STRT | CMD_WRTE;
                     m_dat <= {req_dev, 1'b0};
                     m_ds  <= 1'b1;
                     phase <= P_ADDR;
                     state <= S_ISSUE;
                  end
               end
            end

            S_ISSUE: state <= S_WAIT1;

            S_WAIT1: state <= S_WAITB;

            S_WAITB: begin
               if (!m_status[0]) state <= S_CHECK;
            end

            S_CHECK: begin
               if (m_fail) begin
                  // Master already idle or command rejected: clear status, no STOP.
                  m_cmd <= CMD_CLRS;
                  m_dat <= '0;
                  m_ds  <= 1'b1;
                  state <= S_CLR;
               end else begin
                  case (phase)
                     P_ADDR, P_RADDR: begin
                        if (!m_ack) begin
                           m_cmd    <= CMD_STOP;
                           m_dat    <= '0;
                           m_ds     <= 1'b1;
                           pend_err <= ERR_ANACK;
                           retry_ok <= (phase == P_ADDR);
                           phase    <= P_STOP;
                           state    <= S_ISSUE;
                        end else if (phase == P_ADDR) begin
                           m_cmd <= CMD_WRTE;
                           m_dat <= reg_q;
                           m_ds  <= 1'b1;
                           phase <= P_REG;
                           state <= S_ISSUE;
                        end else begin
                           m_cmd <= is_last ? (CMD_READ | CMD_NACK | CMD_STOP) : CMD_READ;
                           m_dat <= '0;
                           m_ds  <= 1'b1;
                           phase <= P_RDATA;
                           state <= S_ISSUE;
                        end
                     end

                     P_REG: begin
                        if (!m_ack) begin
                           m_cmd    <= CMD_STOP;
                           m_dat    <= '0;
                           m_ds     <= 1'b1;
                           pend_err <= ERR_DNACK;
                           retry_ok <= 1'b0;
                           phase    <= P_STOP;
                           state    <= S_ISSUE;
                        end else if (rd_q) begin
                           m_cmd <= CMD_STRT | CMD_WRTE;
                           m_dat <= {dev_q, 1'b1};
                           m_ds  <= 1'b1;
                           phase <= P_RADDR;
                           state <= S_ISSUE;
                        end else begin
                           phase <= P_WDATA;
                           state <= S_WDAT;
                        end
                     end

                     P_WDATA: begin
                        if (!m_ack) begin
                           m_cmd    <= CMD_STOP;
                           m_dat    <= '0;
                           m_ds     <= 1'b1;
                           pend_err <= ERR_DNACK;
                           retry_ok <= 1'b0;
                           phase    <= P_STOP;
                           state    <= S_ISSUE;
                        end else begin
                           cnt <= cnt - LEN_W'(1);
                           if (is_last) begin
                              err   <= ERR_OK;
                              done  <= 1'b1;
                              state <= S_DONE;
                           end else begin
                              state <= S_WDAT;
                           end
                        end
                     end

                     P_RDATA: begin
                        rd_data  <= m_rdat;
                        rd_valid <= 1'b1;
                        cnt      <= cnt - LEN_W'(1);
                        if (is_last) begin
                           err   <= ERR_OK;
                           done  <= 1'b1;
                           state <= S_DONE;
                        end else begin
                           m_cmd <= is_next_last ? (CMD_READ | CMD_NACK | CMD_STOP) : CMD_READ;
                           m_dat <= '0;
                           m_ds  <= 1'b1;
                           state <= S_ISSUE;
                        end
                     end

                     P_STOP: begin
                        // STOP finished; optionally restart the whole request after an address NACK.
                        if (RETRY_EN && retry_ok && (32'(retry_cnt) < RETRIES)) begin
                           retry_cnt <= retry_cnt + 2'd1;
                           retry_ok  <= 1'b0;
                           m_cmd     <= CMD_STRT | CMD_WRTE;
                           m_dat     <= {dev_q, 1'b0};
                           m_ds      <= 1'b1;
                           phase     <= P_ADDR;
                           state     <= S_ISSUE;
                        end else begin
                           err   <= pend_err;
                           done  <= 1'b1;
                           state <= S_DONE;
                        end
                     end

                     default: state <= S_IDLE;
                  endcase
               end
            end

            S_WDAT: begin
               if (wr_valid) begin
                  wr_ready <= 1'b1;
                  m_dat    <= wr_data;
                  m_cmd    <= is_last ? (CMD_WRTE | CMD_STOP) : CMD_WRTE;
                  m_ds     <= 1'b1;
                  state    <= S_ISSUE;
               end
            end

            S_CLR: state <= S_CLRW;

            S_CLRW: begin
               err   <= ERR_MSTR;
               done  <= 1'b1;
               state <= S_DONE;
            end

            S_DONE: begin
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_xfer_seq.sv
// Directed bench for i2c_xfer_seq with a small behavioural model of the i2c_m status/data interface.
module tb_i2c_xfer_seq;
   localparam int unsigned LEN_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             req_valid = 1'b0;
   logic             req_ready;
   logic             req_rd = 1'b0;
   logic [6:0]       req_dev = '0;
   logic [7:0]       req_reg = '0;
   logic [LEN_W-1:0] req_len = '0;
   logic [7:0]       wr_data;
   logic             wr_valid;
   logic             wr_ready;
   logic [7:0]       rd_data;
   logic             rd_valid;
   logic             done;
   logic [1:0]       err;
   logic [4:0]       m_cmd;
   logic [7:0]       m_dat;
   logic             m_ds;
   logic [3:0]       m_status;
   logic [7:0]       m_rdat;

   always #5 clk = ~clk;

   i2c_xfer_seq #(.LEN_W(LEN_W), .RETRIES(3)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
      .req_dev(req_dev), .req_reg(req_reg), .req_len(req_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err),
      .m_cmd(m_cmd), .m_dat(m_dat), .m_ds(m_ds),
      .m_status(m_status), .m_rdat(m_rdat)
   );

   int nvec  = 0;
   int nfail = 0;

   // Master model controls (written only by the stimulus process)
   logic [6:0] slave_addr = 7'h3b;
   logic       nack_reg   = 1'b0;
   logic       inject_err = 1'b0;

   // Master model state
   logic       bsy, err_f, alo_f, ack_f;
   int         bcnt;
   int         rd_i;
   logic [12:0] log_q[$];

   assign m_status = {ack_f, alo_f, err_f, bsy};

   function automatic logic [7:0] rd_byte(input int k);
      return 8'(32'hA3 + k * 7);
   endfunction

   always @(posedge clk) begin
      if (!rst) begin
         bsy <= 1'b0; err_f <= 1'b0; alo_f <= 1'b0; ack_f <= 1'b0;
         m_rdat <= '0; bcnt <= 0; rd_i <= 0;
      end else if (m_ds) begin
         log_q.push_back({m_cmd, m_dat});
         bsy  <= 1'b1;
         bcnt <= 2;
         if (m_cmd == 5'h00) begin
            err_f <= 1'b0; alo_f <= 1'b0;
         end else if (inject_err) begin
            err_f <= 1'b1; alo_f <= 1'b1;
         end
         if (m_cmd[0])      ack_f <= (m_dat[7:1] == slave_addr);
         else if (m_cmd[3]) ack_f <= !nack_reg;
         if (m_cmd[2]) begin
            m_rdat <= rd_byte(rd_i);
            rd_i   <= rd_i + 1;
         end
      end else if (bsy) begin
         if (bcnt == 0) bsy <= 1'b0;
         else           bcnt <= bcnt - 1;
      end
   end

   // Write-byte source and output monitors
   int         wr_i = 0;
   int         wr_n = 0;
   logic [7:0] wr_bytes[16];
   int         wr_pulses = 0;
   int         done_cnt  = 0;
   int         ds_cnt    = 0;
   logic [7:0] rd_got[$];

   assign wr_valid = rst && (wr_i < wr_n);
   assign wr_data  = wr_bytes[wr_i[3:0]];

   always @(negedge clk) begin
      if (rst) begin
         if (wr_ready) begin
            wr_pulses = wr_pulses + 1;
            wr_i      = wr_i + 1;
         end
         if (rd_valid) rd_got.push_back(rd_data);
         if (done)     done_cnt = done_cnt + 1;
         if (m_ds)     ds_cnt = ds_cnt + 1;
      end
   end

   task automatic load_wr(input logic [7:0] b0, input logic [7:0] b1);
      wr_bytes[4'(wr_n)]     = b0;
      wr_bytes[4'(wr_n + 1)] = b1;
      wr_n = wr_n + 2;
   endtask

   task automatic start_req(input logic rd, input logic [6:0] dev, input logic [7:0] rg,
                            input logic [LEN_W-1:0] len);
      req_rd = rd; req_dev = dev; req_reg = rg; req_len = len; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; req_rd = ~rd; req_dev = 7'h55; req_reg = 8'hee; req_len = LEN_W'(7);
   endtask

   task automatic wait_done(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         nvec++; nfail++;
         $display("FAIL %s: done never pulsed within 400 cycles", name);
      end
   endtask

   task automatic test_reset();
      nvec++;
      if (req_ready !== 1'b1) begin nfail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
      nvec++;
      if ({m_cmd, m_dat, m_ds} !== 14'h0) begin
         nfail++; $display("FAIL reset_master_if: got cmd=%h dat=%h ds=%b want 0", m_cmd, m_dat, m_ds);
      end
      nvec++;
      if ({done, err, wr_ready, rd_valid, rd_data} !== 13'h0) begin
         nfail++; $display("FAIL reset_outputs: done=%b err=%0d wr_ready=%b rd_valid=%b rd_data=%h want 0",
                           done, err, wr_ready, rd_valid, rd_data);
      end
   endtask

   task automatic test_write();
      logic [12:0] exp[4];
      int wb;
      bit ok;
      exp = '{13'h0976, 13'h0810, 13'h085a, 13'h0aa5};
      log_q.delete();
      wb = wr_pulses;
      load_wr(8'h5a, 8'ha5);
      start_req(1'b0, 7'h3b, 8'h10, LEN_W'(2));
      wait_done("write", ok);
      if (ok) begin
         nvec++;
         if (err !== 2'd0) begin nfail++; $display("FAIL write_err: got %0d want 0", err); end
         nvec++;
         if (req_ready !== 1'b0) begin nfail++; $display("FAIL write_ready_in_done: got %b want 0", req_ready); end
      end
      @(negedge clk);
      nvec++;
      if (req_ready !== 1'b1) begin nfail++; $display("FAIL write_ready_after: got %b want 1", req_ready); end
      nvec++;
      if (log_q.size() !== 4) begin nfail++; $display("FAIL write_len: got %0d issues want 4", log_q.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < log_q.size()) begin
            nvec++;
            if (log_q[i] !== exp[i]) begin
               nfail++; $display("FAIL write_seq[%0d]: got cmd/dat %h want %h", i, log_q[i], exp[i]);
            end
         end
      end
      nvec++;
      if (wr_pulses - wb !== 2) begin nfail++; $display("FAIL write_wr_ready: got %0d pulses want 2", wr_pulses - wb); end
   endtask

   task automatic test_read();
      int r0, k0;
      bit ok;
      log_q.delete();
      r0 = rd_got.size();
      k0 = rd_i;
      start_req(1'b1, 7'h3b, 8'h00, LEN_W'(2));
      wait_done("read", ok);
      if (ok) begin
         nvec++;
         if (err !== 2'd0) begin nfail++; $display("FAIL read_err: got %0d want 0", err); end
      end
      @(negedge clk);
      nvec++;
      if (log_q.size() !== 5) begin nfail++; $display("FAIL read_len: got %0d issues want 5", log_q.size()); end
      if (log_q.size() == 5) begin
         nvec++;
         if (log_q[0] !== 13'h0976) begin nfail++; $display("FAIL read_seq0: got %h want 0976", log_q[0]); end
         nvec++;
         if (log_q[1] !== 13'h0800) begin nfail++; $display("FAIL read_seq1: got %h want 0800", log_q[1]); end
         nvec++;
         if (log_q[2] !== 13'h0977) begin nfail++; $display("FAIL read_seq2: got %h want 0977", log_q[2]); end
         nvec++;
         if (log_q[3][12:8] !== 5'h04) begin nfail++; $display("FAIL read_seq3: got cmd %h want 04", log_q[3][12:8]); end
         nvec++;
         if (log_q[4][12:8] !== 5'h16) begin nfail++; $display("FAIL read_seq4: got cmd %h want 16", log_q[4][12:8]); end
      end
      nvec++;
      if (rd_got.size() - r0 !== 2) begin
         nfail++; $display("FAIL read_rd_valid: got %0d pulses want 2", rd_got.size() - r0);
      end else begin
         nvec++;
         if (rd_got[r0] !== rd_byte(k0)) begin
            nfail++; $display("FAIL read_byte0: got %h want %h", rd_got[r0], rd_byte(k0));
         end
         nvec++;
         if (rd_got[r0 + 1] !== rd_byte(k0 + 1)) begin
            nfail++; $display("FAIL read_byte1: got %h want %h", rd_got[r0 + 1], rd_byte(k0 + 1));
         end
      end
   endtask

   task automatic test_read_len1();
      int r0, k0;
      bit ok;
      log_q.delete();
      r0 = rd_got.size();
      k0 = rd_i;
      start_req(1'b1, 7'h3b, 8'h42, LEN_W'(1));
      wait_done("read1", ok);
      if (ok) begin
         nvec++;
         if (err !== 2'd0) begin nfail++; $display("FAIL read1_err: got %0d want 0", err); end
      end
      @(negedge clk);
      nvec++;
      if (log_q.size() !== 4) begin
         nfail++; $display("FAIL read1_len: got %0d issues want 4", log_q.size());
      end else begin
         nvec++;
         if (log_q[1] !== 13'h0842) begin nfail++; $display("FAIL read1_reg: got %h want 0842", log_q[1]); end
         nvec++;
         if (log_q[3][12:8] !== 5'h16) begin nfail++; $display("FAIL read1_last: got cmd %h want 16", log_q[3][12:8]); end
      end
      nvec++;
      if (rd_got.size() - r0 !== 1 || rd_got[r0] !== rd_byte(k0)) begin
         nfail++; $display("FAIL read1_data: got %0d bytes first %h want 1 byte %h",
                           rd_got.size() - r0, (rd_got.size() > r0) ? rd_got[r0] : 8'h00, rd_byte(k0));
      end
   endtask

   task automatic test_addr_nack();
      int n_att;
      bit ok;
`ifdef I2C_SEQ_RETRY_EN
      n_att = 4;
`else
      n_att = 1;
`endif
      log_q.delete();
      start_req(1'b0, 7'h12, 8'h10, LEN_W'(1));
      wait_done("addr_nack", ok);
      if (ok) begin
         nvec++;
         if (err !== 2'd1) begin nfail++; $display("FAIL anack_err: got %0d want 1", err); end
      end
      @(negedge clk);
      nvec++;
      if (log_q.size() !== 2 * n_att) begin
         nfail++; $display("FAIL anack_len: got %0d issues want %0d", log_q.size(), 2 * n_att);
      end else begin
         for (int k = 0; k < n_att; k++) begin
            nvec++;
            if (log_q[2 * k] !== 13'h0924 || log_q[2 * k + 1][12:8] !== 5'h02) begin
               nfail++; $display("FAIL anack_attempt%0d: got %h,%h want 0924,02xx", k, log_q[2 * k], log_q[2 * k + 1]);
            end
         end
      end
   endtask

   task automatic test_data_nack();
      int wb;
      bit ok;
      log_q.delete();
      wb = wr_pulses;
      nack_reg = 1'b1;
      start_req(1'b0, 7'h3b, 8'h10, LEN_W'(2));
      wait_done("data_nack", ok);
      if (ok) begin
         nvec++;
         if (err !== 2'd2) begin nfail++; $display("FAIL dnack_err: got %0d want 2", err); end
      end
      @(negedge clk);
      nack_reg = 1'b0;
      nvec++;
      if (log_q.size() !== 3) begin
         nfail++; $display("FAIL dnack_len: got %0d issues want 3", log_q.size());
      end else begin
         nvec++;
         if (log_q[1] !== 13'h0810 || log_q[2][12:8] !== 5'h02) begin
            nfail++; $display("FAIL dnack_seq: got %h,%h want 0810,02xx", log_q[1], log_q[2]);
         end
      end
      nvec++;
      if (wr_pulses !== wb) begin nfail++; $display("FAIL dnack_wr_ready: got %0d pulses want 0", wr_pulses - wb); end
   endtask

   task automatic test_master_err();
      bit ok;
      log_q.delete();
      inject_err = 1'b1;
      start_req(1'b1, 7'h3b, 8'h00, LEN_W'(2));
      wait_done("master_err", ok);
      if (ok) begin
         nvec++;
         if (err !== 2'd3) begin nfail++; $display("FAIL merr_err: got %0d want 3", err); end
      end
      @(negedge clk);
      inject_err = 1'b0;
      nvec++;
      if (req_ready !== 1'b1) begin nfail++; $display("FAIL merr_ready: got %b want 1", req_ready); end
      nvec++;
      if (log_q.size() !== 2 || log_q[0] !== 13'h0976 || log_q[1] !== 13'h0000) begin
         nfail++; $display("FAIL merr_seq: got %0d issues first %h last %h want 0976 then 0000",
                           log_q.size(), (log_q.size() > 0) ? log_q[0] : 13'h1fff,
                           (log_q.size() > 1) ? log_q[log_q.size() - 1] : 13'h1fff);
      end
   endtask

   task automatic test_len_zero();
      int ds0;
      log_q.delete();
      ds0 = ds_cnt;
      start_req(1'b0, 7'h3b, 8'h10, LEN_W'(0));
      nvec++;
      if (done !== 1'b1 || err !== 2'd3) begin
         nfail++; $display("FAIL len0_done: got done=%b err=%0d want done=1 err=3", done, err);
      end
      @(negedge clk);
      nvec++;
      if (done !== 1'b0 || req_ready !== 1'b1) begin
         nfail++; $display("FAIL len0_idle: got done=%b ready=%b want 0,1", done, req_ready);
      end
      repeat (3) @(negedge clk);
      nvec++;
      if (ds_cnt !== ds0 || log_q.size() !== 0) begin
         nfail++; $display("FAIL len0_bus: got %0d ds pulses want 0", ds_cnt - ds0);
      end
   endtask

   task automatic test_reset_mid();
      int d0;
      bit hit;
      log_q.delete();
      load_wr(8'h11, 8'h22);
      start_req(1'b0, 7'h3b, 8'h10, LEN_W'(2));
      hit = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (log_q.size() >= 4) begin
            hit = 1'b1;
            break;
         end
         @(negedge clk);
      end
      nvec++;
      if (!hit) begin nfail++; $display("FAIL rstmid_reach: got %0d issues want 4", log_q.size()); end
      d0 = done_cnt;
      rst = 1'b0;
      @(negedge clk);
      nvec++;
      if (req_ready !== 1'b1 || m_ds !== 1'b0 || done !== 1'b0) begin
         nfail++; $display("FAIL rstmid_idle: got ready=%b ds=%b done=%b want 1,0,0", req_ready, m_ds, done);
      end
      rst = 1'b1;
      wr_n = wr_i;
      repeat (5) @(negedge clk);
      nvec++;
      if (done_cnt !== d0 || req_ready !== 1'b1) begin
         nfail++; $display("FAIL rstmid_quiet: got %0d done pulses ready=%b want 0,1", done_cnt - d0, req_ready);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      test_write();
      test_read();
      test_read_len1();
      test_addr_nack();
      test_data_nack();
      test_master_err();
      test_len_zero();
      test_reset_mid();
      test_write();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      repeat (20000) @(posedge clk);
      $display("FAIL watchdog: simulation exceeded 20000 cycles");
      $fatal(1);
   end

endmodule
